// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bit-counter width for a given operand width (CNT_W = $clog2(WIDTH)).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, Diff = A - B - Bin over WIDTH cycles, LSB first.
// Optional signed-overflow output Ovf when SERIAL_SUBTRACTOR_OVF_EN is defined.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands; last result held on Diff/Bout/Zero
// RUN   | one bit per cycle through the shared full-subtractor cell
// DONE  | out_valid=1, result held until out_ready
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             Ovf,
`endif
  output logic             Zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [CNT_W-1:0] cnt;
  logic             br, br_next, d_bit;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, zero_q;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  // New bit enters at the MSB so after WIDTH shifts the LSB has reached bit 0.
  assign res_next = WIDTH'({d_bit, res_sr} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)       state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= A;
            b_sr   <= B;
            br     <= Bin;
            res_sr <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_next;
          res_sr <= res_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            diff_q <= res_next;
            bout_q <= br_next;
            zero_q <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_q;

  // Borrow into the MSB differs from borrow out of it exactly on signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (state == RUN && cnt == CNT_LAST)
      ovf_q <= br ^ br_next;
  end

  assign Ovf = ovf_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Diff      = diff_q;
  assign Bout      = bout_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations against
// an arithmetic reference model, including backpressure and reset aborts.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         Zero;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         Ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .Ovf       (Ovf),
`endif
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic, unsigned and two's-complement views.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic z,
                       output logic ov);
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'(a);
    ub = longint'(b);
    ur = ua - ub - longint'(bin);
    d  = W'(ur);
    bo = (ur < 0);
    z  = (d == '0);
    sa = (ua >= (64'sd1 << (W - 1))) ? ua - (64'sd1 << W) : ua;
    sb = (ub >= (64'sd1 << (W - 1))) ? ub - (64'sd1 << W) : ub;
    sr = sa - sb - longint'(bin);
    ov = (sr < -(64'sd1 << (W - 1))) || (sr > (64'sd1 << (W - 1)) - 1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int hold);
    logic [W-1:0] ed;
    logic eb, ez, eo;
    int n;
    model(a, b, bin, ed, eb, ez, eo);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    check("in_ready_run", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(W));
    check("diff", 32'(Diff), 32'(ed));
    check("bout", 32'(Bout), 32'(eb));
    check("zero", 32'(Zero), 32'(ez));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("ovf", 32'(Ovf), 32'(eo));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_diff", 32'(Diff), 32'(ed));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drop_valid", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_diff_kept", 32'(Diff), 32'(ed));
  endtask

  initial begin
    int seen;
    logic [W-1:0] ed;
    logic eb, ez, eo;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(Diff), 32'd0);
      check("rst_bout", 32'(Bout), 32'd0);
      check("rst_zero", 32'(Zero), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("rst_ovf", 32'(Ovf), 32'd0);
`endif
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the arithmetic corners
    do_op(4'd9, 4'd3, 1'b0, 0);
    do_op(4'd3, 4'd9, 1'b0, 0);
    do_op(4'd0, 4'd0, 1'b1, 0);
    do_op(4'd5, 4'd5, 1'b0, 0);
    do_op(4'd7, 4'hF, 1'b0, 0);
    do_op(4'd8, 4'd1, 1'b0, 0);
    do_op(4'd6, 4'd2, 1'b0, 0);
    do_op(4'hF, 4'hF, 1'b1, 0);
    // Backpressure
    do_op(4'd12, 4'd5, 1'b1, 5);

    // Random operations with random backpressure
    for (int i = 0; i < 30; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Async reset in DONE: outputs clear without a clock edge
    do_op(4'd9, 4'd2, 1'b0, 0);
    A = 4'd10; B = 4'd1; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    check("async_rst_diff", 32'(Diff), 32'd0);
    check("async_rst_bout", 32'(Bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during RUN at cnt=2 aborts with no result
    A = 4'd14; B = 4'd3; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("run_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    model(4'd14, 4'd3, 1'b0, ed, eb, ez, eo);
    check("abort_diff_clear", 32'(Diff), 32'd0);
    do_op(4'd14, 4'd3, 1'b0, 1);
    check("post_abort_diff", 32'(Diff), 32'(ed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
